// File: rtl/sram_like_demux2.sv
// rtl/sram_like_demux2.sv - splits one SRAM-like master bus onto two slaves by address
// Responses return in issue order; only one slave may have transactions in flight at a time.
module sram_like_demux2 #(
   parameter int                 ADDR_W    = 32,
   parameter int                 DATA_W    = 32,
   parameter int                 MAX_OUT   = 4,
   parameter logic [ADDR_W-1:0]  SEL_MASK  = 32'hE000_0000,
   parameter logic [ADDR_W-1:0]  SEL_MATCH = 32'hA000_0000
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m_req,
   input  logic              m_wr,
   input  logic [1:0]        m_size,
   input  logic [ADDR_W-1:0] m_addr,
   input  logic [DATA_W-1:0] m_wdata,
   output logic              m_addr_ok,
   output logic              m_data_ok,
   output logic [DATA_W-1:0] m_rdata,
   output logic              s0_req,
   output logic              s0_wr,
   output logic [1:0]        s0_size,
   output logic [ADDR_W-1:0] s0_addr,
   output logic [DATA_W-1:0] s0_wdata,
   input  logic              s0_addr_ok,
   input  logic              s0_data_ok,
   input  logic [DATA_W-1:0] s0_rdata,
   output logic              s1_req,
   output logic              s1_wr,
   output logic [1:0]        s1_size,
   output logic [ADDR_W-1:0] s1_addr,
   output logic [DATA_W-1:0] s1_wdata,
   input  logic              s1_addr_ok,
   input  logic              s1_data_ok,
   input  logic [DATA_W-1:0] s1_rdata
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_cur_tgt;

   logic w_tgt;
   logic w_full;
   logic w_idle;
   logic w_grant;
   logic w_tgt_addr_ok;
   logic w_cur_data_ok;

   assign w_tgt  = ((m_addr & SEL_MASK) == SEL_MATCH);
   assign w_full = (r_cnt == CNT_W'(MAX_OUT));
   assign w_idle = (r_cnt == '0);

   // Switching slaves waits for the pipe to drain so responses cannot reorder.
   assign w_grant = m_req & ~w_full & (w_idle | (r_cur_tgt == w_tgt));

   assign s0_req = w_grant & ~w_tgt;
   assign s1_req = w_grant &  w_tgt;

   assign s0_wr    = m_wr;
   assign s0_size  = m_size;
   assign s0_addr  = m_addr;
   assign s0_wdata = m_wdata;
   assign s1_wr    = m_wr;
   assign s1_size  = m_size;
   assign s1_addr  = m_addr;
   assign s1_wdata = m_wdata;

   assign w_tgt_addr_ok = w_tgt ? s1_addr_ok : s0_addr_ok;
   assign m_addr_ok     = w_grant & w_tgt_addr_ok;

   assign w_cur_data_ok = r_cur_tgt ? s1_data_ok : s0_data_ok;
   assign m_data_ok     = ~w_idle & w_cur_data_ok;
   assign m_rdata       = r_cur_tgt ? s1_rdata : s0_rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt     <= '0;
         r_cur_tgt <= 1'b0;
      end else begin
         if (m_addr_ok)
            r_cur_tgt <= w_tgt;
         case ({m_addr_ok, m_data_ok})
            2'b10:   r_cnt <= r_cnt + CNT_W'(1);
            2'b01:   r_cnt <= r_cnt - CNT_W'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_like_demux2.sv
// tb/tb_sram_like_demux2.sv - scoreboard bench for sram_like_demux2
module tb_sram_like_demux2;

   logic        clk = 1'b0;
   logic        resetn;
   logic        m_req, m_wr;
   logic [1:0]  m_size;
   logic [31:0] m_addr, m_wdata;
   logic        m_addr_ok, m_data_ok;
   logic [31:0] m_rdata;
   logic        s0_req, s0_wr, s1_req, s1_wr;
   logic [1:0]  s0_size, s1_size;
   logic [31:0] s0_addr, s0_wdata, s1_addr, s1_wdata;
   logic        s0_addr_ok, s0_data_ok, s1_addr_ok, s1_data_ok;
   logic [31:0] s0_rdata, s1_rdata;

   int total = 0;
   int bad   = 0;

   logic [31:0] exp_q[$];
   logic [31:0] slv0_q[$];
   logic [31:0] slv1_q[$];

   always #5 clk = ~clk;

   sram_like_demux2 dut (
      .clk(clk), .resetn(resetn),
      .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
      .s0_req(s0_req), .s0_wr(s0_wr), .s0_size(s0_size), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
      .s0_addr_ok(s0_addr_ok), .s0_data_ok(s0_data_ok), .s0_rdata(s0_rdata),
      .s1_req(s1_req), .s1_wr(s1_wr), .s1_size(s1_size), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
      .s1_addr_ok(s1_addr_ok), .s1_data_ok(s1_data_ok), .s1_rdata(s1_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      m_req   = 1'b1;
      m_wr    = wr;
      m_size  = 2'd2;
      m_addr  = addr;
      m_wdata = wd;
   endtask

   // One accepted request; rd is the data the owning slave will later return.
   task automatic issue(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] rd, input logic tgt);
      set_req(wr, addr, ~rd);
      s0_addr_ok = 1'b1;
      s1_addr_ok = 1'b1;
      #1;
      chk({tag, ".addr_ok"}, {31'd0, m_addr_ok}, 32'd1);
      chk({tag, ".s0_req"},  {31'd0, s0_req},    {31'd0, ~tgt});
      chk({tag, ".s1_req"},  {31'd0, s1_req},    {31'd0, tgt});
      chk({tag, ".addr"},    tgt ? s1_addr : s0_addr, addr);
      chk({tag, ".wr"},      {31'd0, tgt ? s1_wr : s0_wr}, {31'd0, wr});
      chk({tag, ".wdata"},   tgt ? s1_wdata : s0_wdata, ~rd);
      exp_q.push_back(rd);
      if (tgt) slv1_q.push_back(rd);
      else     slv0_q.push_back(rd);
      tick;
      m_req      = 1'b0;
      s0_addr_ok = 1'b0;
      s1_addr_ok = 1'b0;
   endtask

   // Slave tgt returns its oldest response; exp_aok >= 0 also checks m_addr_ok that cycle.
   task automatic respond(input string tag, input logic tgt, input int exp_aok);
      logic [31:0] d;
      if ((tgt ? slv1_q.size() : slv0_q.size()) == 0 || exp_q.size() == 0) begin
         chk({tag, ".queue_empty"}, 32'd1, 32'd0);
         return;
      end
      d = tgt ? slv1_q.pop_front() : slv0_q.pop_front();
      if (tgt) begin s1_data_ok = 1'b1; s1_rdata = d; end
      else     begin s0_data_ok = 1'b1; s0_rdata = d; end
      #1;
      chk({tag, ".data_ok"}, {31'd0, m_data_ok}, 32'd1);
      chk({tag, ".rdata"},   m_rdata, exp_q.pop_front());
      if (exp_aok >= 0)
         chk({tag, ".aok"}, {31'd0, m_addr_ok}, exp_aok[31:0]);
      tick;
      s0_data_ok = 1'b0;
      s1_data_ok = 1'b0;
   endtask

   task automatic stray(input string tag, input logic tgt);
      if (tgt) begin s1_data_ok = 1'b1; s1_rdata = 32'hDEAD_0001; end
      else     begin s0_data_ok = 1'b1; s0_rdata = 32'hDEAD_0000; end
      #1;
      chk({tag, ".stray"}, {31'd0, m_data_ok}, 32'd0);
      tick;
      s0_data_ok = 1'b0;
      s1_data_ok = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      m_req = 1'b0; m_wr = 1'b0; m_size = 2'd0; m_addr = '0; m_wdata = '0;
      s0_addr_ok = 1'b0; s0_data_ok = 1'b1; s0_rdata = 32'h5A5A_5A5A;
      s1_addr_ok = 1'b0; s1_data_ok = 1'b0; s1_rdata = '0;

      // 1: reset holds off responses; first read after release goes to s0
      #1;
      chk("t1.rst_data_ok", {31'd0, m_data_ok}, 32'd0);
      chk("t1.rst_addr_ok", {31'd0, m_addr_ok}, 32'd0);
      tick; tick;
      resetn = 1'b1;
      s0_data_ok = 1'b0;
      stray("t1.idle", 1'b0);
      issue("t1.rd", 1'b0, 32'h0000_1000, 32'h1111_1000, 1'b0);
      respond("t1.rsp", 1'b0, -1);

      // 2: uncached read routes to s1
      issue("t2.rd", 1'b0, 32'hBFC0_0000, 32'h1234_5678, 1'b1);
      respond("t2.rsp", 1'b1, -1);
      stray("t2.after", 1'b1);

      // 3: four outstanding fills the window; same-cycle data_ok does not free a slot
      for (int i = 0; i < 4; i++)
         issue($sformatf("t3.rd%0d", i), 1'b0, 32'h0000_2000 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 1'b0);
      set_req(1'b0, 32'h0000_2010, 32'h0);
      s0_addr_ok = 1'b1;
      #1;
      chk("t3.full.s0_req", {31'd0, s0_req}, 32'd0);
      chk("t3.full.aok",    {31'd0, m_addr_ok}, 32'd0);
      tick;
      chk("t3.full2.aok",   {31'd0, m_addr_ok}, 32'd0);
      respond("t3.free", 1'b0, 0);
      issue("t3.rd4", 1'b0, 32'h0000_2010, 32'hC0DE_0004, 1'b0);
      for (int i = 0; i < 4; i++)
         respond($sformatf("t3.drain%0d", i), 1'b0, -1);

      // 4: write to the other slave stalls until the s0 read drains
      issue("t4.rd", 1'b0, 32'h0000_0040, 32'h4444_0040, 1'b0);
      set_req(1'b1, 32'hA000_0000, 32'h0);
      s0_addr_ok = 1'b1;
      s1_addr_ok = 1'b1;
      #1;
      chk("t4.stall.s1_req", {31'd0, s1_req}, 32'd0);
      chk("t4.stall.s0_req", {31'd0, s0_req}, 32'd0);
      chk("t4.stall.aok",    {31'd0, m_addr_ok}, 32'd0);
      tick;
      chk("t4.stall2.s1_req", {31'd0, s1_req}, 32'd0);
      respond("t4.rsp", 1'b0, 0);
      issue("t4.wr", 1'b1, 32'hA000_0000, 32'h0BAD_F00D, 1'b1);
      respond("t4.wrsp", 1'b1, -1);

      // 5: issue and response in one cycle leave the count unchanged
      issue("t5.rd0", 1'b0, 32'h0000_0100, 32'h5555_0100, 1'b0);
      issue("t5.rd1", 1'b0, 32'h0000_0104, 32'h5555_0104, 1'b0);
      set_req(1'b0, 32'h0000_0108, 32'hAAAA_FEF7);
      s0_addr_ok = 1'b1;
      s0_data_ok = 1'b1;
      s0_rdata   = slv0_q.pop_front();
      #1;
      chk("t5.both.aok",   {31'd0, m_addr_ok}, 32'd1);
      chk("t5.both.dok",   {31'd0, m_data_ok}, 32'd1);
      chk("t5.both.rdata", m_rdata, exp_q.pop_front());
      exp_q.push_back(32'h5555_0108);
      slv0_q.push_back(32'h5555_0108);
      tick;
      m_req = 1'b0; s0_addr_ok = 1'b0; s0_data_ok = 1'b0;
      stray("t5.s1", 1'b1);
      respond("t5.drain0", 1'b0, -1);
      respond("t5.drain1", 1'b0, -1);
      stray("t5.empty", 1'b0);

      // 6: reset mid-burst discards in-flight work
      for (int i = 0; i < 3; i++)
         issue($sformatf("t6.rd%0d", i), 1'b0, 32'hA000_1000 + 32'(4 * i), 32'h6666_0000 + 32'(i), 1'b1);
      s1_data_ok = 1'b1;
      s1_rdata   = 32'h6666_0000;
      #1;
      chk("t6.pre.dok", {31'd0, m_data_ok}, 32'd1);
      resetn = 1'b0;
      #1;
      chk("t6.rst.dok", {31'd0, m_data_ok}, 32'd0);
      tick;
      resetn = 1'b1;
      s1_data_ok = 1'b0;
      exp_q.delete();
      slv0_q.delete();
      slv1_q.delete();
      issue("t6.s0", 1'b0, 32'h0000_3000, 32'h7777_3000, 1'b0);
      respond("t6.s0rsp", 1'b0, -1);
      issue("t6.s1", 1'b0, 32'hA000_3000, 32'h7777_A000, 1'b1);
      respond("t6.s1rsp", 1'b1, -1);
      chk("end.queue", exp_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
